// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit and the memory it talks to.
//   - RISC-V funct3 size/sign encodings
//   - FSM state and fault-code enums
//   - memory-map boundary constants (ROM below, RAM above LSU_RAM_SEL_BIT)
//   - funct3_legal(): which funct3 codes are valid for a load or a store
package lsu_pkg;

  // Highest legal address bit.  Everything above it must be zero.
  localparam int LSU_MAP_TOP_BIT = 10;
  // This address bit picks the region: 0 = ROM, 1 = RAM.
  localparam int LSU_RAM_SEL_BIT = 10;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD,
    ST_WR,
    ST_RESP,
    ST_FAULT
  } lsu_state_e;

  typedef enum logic [1:0] {
    FLT_NONE     = 2'd0,
    FLT_MISALIGN = 2'd1,
    FLT_FUNCT3   = 2'd2,
    FLT_REGION   = 2'd3
  } lsu_fault_e;

  // Stores have no unsigned variants, so they only accept B/H/W.
  function automatic logic funct3_legal(input logic write, input logic [2:0] f3);
    if (write) return f3 inside {F3_B, F3_H, F3_W};
    return f3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU};
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Bus bundle for the load/store unit: the CPU request/response channel and
// the word-wide memory channel.
//   master : the load/store unit's view (takes requests, drives memory)
//   slave  : the environment's view (CPU issues requests, memory answers)
interface load_store_unit_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [2:0]        req_funct3;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;

  logic              resp_valid;
  logic [DATA_W-1:0] resp_rdata;
  logic [1:0]        resp_fault;

  logic              mem_valid;
  logic              mem_ready;
  logic [ADDR_W-1:0] mem_address;
  logic              mem_read_write;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    input  req_valid, req_write, req_funct3, req_addr, req_wdata,
    input  mem_ready, mem_rdata,
    output req_ready, resp_valid, resp_rdata, resp_fault,
    output mem_valid, mem_address, mem_read_write, mem_wdata
  );

  modport slave (
    output req_valid, req_write, req_funct3, req_addr, req_wdata,
    output mem_ready, mem_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_fault,
    input  mem_valid, mem_address, mem_read_write, mem_wdata
  );
endinterface

// File: rtl/lsu_lane_align.sv
// Combinational byte-lane handling for the load/store unit.
//   i_addr_lo : byte offset within the word (addr[1:0])
//   i_funct3  : access size/sign
//   i_rword   : word read from memory
//   i_wdata   : right-aligned store data
//   o_load    : selected lane, sign/zero-extended to a full word
//   o_merge   : word to write back (store lane(s) spliced into i_rword;
//               full store data for a word store)
module lsu_lane_align
  import lsu_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [1:0]        i_addr_lo,
  input  logic [2:0]        i_funct3,
  input  logic [DATA_W-1:0] i_rword,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] o_load,
  output logic [DATA_W-1:0] o_merge
);
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Little-endian: byte n sits at bits [8n+7:8n]; a halfword uses addr[1] only
  // because misaligned halves never reach this point.
  assign w_byte = i_rword[{i_addr_lo, 3'b000} +: 8];
  assign w_half = i_rword[{i_addr_lo[1], 4'b0000} +: 16];

  always_comb begin
    o_load = i_rword;
    case (i_funct3)
      F3_B:    o_load = {{(DATA_W-8){w_byte[7]}}, w_byte};
      F3_BU:   o_load = {{(DATA_W-8){1'b0}}, w_byte};
      F3_H:    o_load = {{(DATA_W-16){w_half[15]}}, w_half};
      F3_HU:   o_load = {{(DATA_W-16){1'b0}}, w_half};
      default: o_load = i_rword;
    endcase
  end

  always_comb begin
    o_merge = i_wdata;
    case (i_funct3)
      F3_B: begin
        o_merge = i_rword;
        o_merge[{i_addr_lo, 3'b000} +: 8] = i_wdata[7:0];
      end
      F3_H: begin
        o_merge = i_rword;
        o_merge[{i_addr_lo[1], 4'b0000} +: 16] = i_wdata[15:0];
      end
      default: o_merge = i_wdata;
    endcase
  end
endmodule

// File: rtl/load_store_unit.sv
// CPU-side initiator for the word-wide instruction/data memory.
// Takes one load/store at a time, checks funct3/alignment/region, then issues
// word accesses.  Sub-word stores are read-modify-write; loads come back
// lane-extracted and extended.  All outputs are registered.
//   clk   : system clock
//   reset : synchronous, active-high; aborts any transaction at once
//   bus   : CPU request/response + memory channel (load_store_unit_if.master)
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int MAP_TOP_BIT = LSU_MAP_TOP_BIT
) (
  input logic               clk,
  input logic               reset,
  load_store_unit_if.master bus
);
  lsu_state_e        r_state;
  logic              r_write;
  logic [2:0]        r_funct3;
  logic [1:0]        r_addr_lo;
  logic [DATA_W-1:0] r_wdata;

  logic              r_req_ready;
  logic              r_resp_valid;
  logic [DATA_W-1:0] r_resp_rdata;
  logic [1:0]        r_resp_fault;
  logic              r_mem_valid;
  logic              r_mem_rw;
  logic [ADDR_W-1:0] r_mem_address;
  logic [DATA_W-1:0] r_mem_wdata;

  logic              w_accept;
  lsu_fault_e        w_fault;
  logic [DATA_W-1:0] w_load;
  logic [DATA_W-1:0] w_merge;

  assign w_accept = bus.req_valid & r_req_ready;

  // Fault priority: funct3 first, then alignment, then region.
  always_comb begin
    w_fault = FLT_NONE;
    if (!funct3_legal(bus.req_write, bus.req_funct3))
      w_fault = FLT_FUNCT3;
    else if ((bus.req_funct3[1:0] == 2'b01 && bus.req_addr[0]) ||
             (bus.req_funct3[1:0] == 2'b10 && bus.req_addr[1:0] != 2'b00))
      w_fault = FLT_MISALIGN;
    else if ((|bus.req_addr[ADDR_W-1:MAP_TOP_BIT+1]) ||
             (bus.req_write && !bus.req_addr[LSU_RAM_SEL_BIT]))
      w_fault = FLT_REGION;
  end

  // Works on the live mem_rdata, so the extracted load value and the merged
  // store word are both captured on the same edge that completes the read.
  lsu_lane_align #(.DATA_W(DATA_W)) u_align (
    .i_addr_lo (r_addr_lo),
    .i_funct3  (r_funct3),
    .i_rword   (bus.mem_rdata),
    .i_wdata   (r_wdata),
    .o_load    (w_load),
    .o_merge   (w_merge)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= ST_IDLE;
      r_write       <= 1'b0;
      r_funct3      <= '0;
      r_addr_lo     <= '0;
      r_wdata       <= '0;
      r_req_ready   <= 1'b1;
      r_resp_valid  <= 1'b0;
      r_resp_rdata  <= '0;
      r_resp_fault  <= '0;
      r_mem_valid   <= 1'b0;
      r_mem_rw      <= 1'b0;
      r_mem_address <= '0;
      r_mem_wdata   <= '0;
    end else begin
      r_resp_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_write     <= bus.req_write;
            r_funct3    <= bus.req_funct3;
            r_addr_lo   <= bus.req_addr[1:0];
            r_wdata     <= bus.req_wdata;
            r_req_ready <= 1'b0;
            if (w_fault != FLT_NONE) begin
              r_state      <= ST_FAULT;
              r_resp_valid <= 1'b1;
              r_resp_fault <= w_fault;
              r_resp_rdata <= '0;
            end else begin
              r_mem_valid   <= 1'b1;
              r_mem_address <= {bus.req_addr[ADDR_W-1:2], 2'b00};
              if (bus.req_write && bus.req_funct3 == F3_W) begin
                // Full-word store needs no read.
                r_state     <= ST_WR;
                r_mem_rw    <= 1'b1;
                r_mem_wdata <= bus.req_wdata;
              end else begin
                r_state  <= ST_RD;
                r_mem_rw <= 1'b0;
              end
            end
          end
        end
        ST_RD: begin
          if (bus.mem_ready) begin
            if (r_write) begin
              r_state     <= ST_WR;
              r_mem_rw    <= 1'b1;
              r_mem_wdata <= w_merge;
            end else begin
              r_state      <= ST_RESP;
              r_mem_valid  <= 1'b0;
              r_resp_valid <= 1'b1;
              r_resp_fault <= FLT_NONE;
              r_resp_rdata <= w_load;
            end
          end
        end
        ST_WR: begin
          if (bus.mem_ready) begin
            r_state      <= ST_RESP;
            r_mem_valid  <= 1'b0;
            r_mem_rw     <= 1'b0;
            r_resp_valid <= 1'b1;
            r_resp_fault <= FLT_NONE;
            r_resp_rdata <= '0;
          end
        end
        ST_RESP, ST_FAULT: begin
          r_state     <= ST_IDLE;
          r_req_ready <= 1'b1;
        end
        default: begin
          r_state     <= ST_IDLE;
          r_req_ready <= 1'b1;
          r_mem_valid <= 1'b0;
        end
      endcase
    end
  end

  assign bus.req_ready      = r_req_ready;
  assign bus.resp_valid     = r_resp_valid;
  assign bus.resp_rdata     = r_resp_rdata;
  assign bus.resp_fault     = r_resp_fault;
  assign bus.mem_valid      = r_mem_valid;
  assign bus.mem_read_write = r_mem_rw;
  assign bus.mem_address    = r_mem_address;
  assign bus.mem_wdata      = r_mem_wdata;
endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench: stimulus pushes expected responses (from a byte-array
// reference model) into queues; a response monitor and the memory responder
// pop and compare independently.
module tb_load_store_unit;
  import lsu_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  load_store_unit_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  load_store_unit dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_chk = 0;
  int n_err = 0;

  typedef struct { logic [31:0] rdata; logic [1:0] fault; } resp_t;
  typedef struct { logic [31:0] addr;  logic [31:0] data;  } wr_t;

  byte unsigned mem_b [0:2047];   // reference model, byte granular
  logic [31:0]  mem_w [0:511];    // memory responder storage, word granular
  resp_t exp_q[$];
  wr_t   wr_q[$];

  bit tie_ready = 1'b1;
  bit rand_dly  = 1'b0;
  int rd_dly    = 0;
  int wr_dly    = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic flag(input string name);
    n_chk++;
    n_err++;
    $display("FAIL %s", name);
  endtask

  // Reference model: plain byte-level memory semantics.
  function automatic resp_t model(input bit w, input logic [2:0] f3,
                                  input logic [31:0] a, input logic [31:0] wd);
    resp_t r;
    int sz;
    bit legal;
    logic [31:0] v;
    r.rdata = '0;
    r.fault = 2'd0;
    legal = w ? (f3 <= 3'd2) : (f3 != 3'd3 && f3 <= 3'd5);
    sz = 1 << f3[1:0];
    if (!legal) r.fault = 2'd2;
    else if (a % sz != 0) r.fault = 2'd1;
    else if (a >= 32'd2048 || (w && a < 32'd1024)) r.fault = 2'd3;
    else if (w) begin
      for (int i = 0; i < sz; i++) mem_b[a + i] = wd[8*i +: 8];
      v = '0;
      for (int i = 0; i < 4; i++) v[8*i +: 8] = mem_b[(a & ~32'd3) + i];
      wr_q.push_back('{a & ~32'd3, v});
    end else begin
      v = '0;
      for (int i = 0; i < sz; i++) v = v | (32'(mem_b[a + i]) << (8*i));
      if (!f3[2] && sz < 4 && v[8*sz-1]) v = v | ~((32'd1 << (8*sz)) - 32'd1);
      r.rdata = v;
    end
    return r;
  endfunction

  task automatic set_word(input logic [31:0] a, input logic [31:0] v);
    mem_w[a[10:2]] = v;
    for (int i = 0; i < 4; i++) mem_b[{a[10:2], 2'b00} + i] = v[8*i +: 8];
  endtask

  // Memory responder: serves reads/writes after a programmed delay, checks
  // that a stalled request holds steady and that writes match the model.
  initial begin
    bit busy;
    int cnt, tgt;
    logic [31:0] s_addr, s_wd;
    logic s_rw;
    wr_t e;
    busy = 0; cnt = 0; tgt = 0;
    bus.mem_ready = 1'b0;
    bus.mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (reset || !bus.mem_valid) begin
        busy = 0;
        bus.mem_ready = tie_ready;
      end else begin
        if (busy) begin
          chk("hold_addr", bus.mem_address, s_addr);
          chk("hold_rw", 32'(bus.mem_read_write), 32'(s_rw));
          chk("hold_wdata", bus.mem_wdata, s_wd);
        end else begin
          busy = 1;
          cnt = 0;
          tgt = rand_dly ? int'($urandom_range(0, 3)) : (bus.mem_read_write ? wr_dly : rd_dly);
        end
        s_addr = bus.mem_address;
        s_rw   = bus.mem_read_write;
        s_wd   = bus.mem_wdata;
        if (cnt >= tgt) begin
          bus.mem_ready = 1'b1;
          bus.mem_rdata = mem_w[bus.mem_address[10:2]];
          if (bus.mem_read_write) begin
            mem_w[bus.mem_address[10:2]] = bus.mem_wdata;
            if (wr_q.size() == 0) begin
              n_chk++; n_err++;
              $display("FAIL mem_write_unexpected: got addr %h data %h", bus.mem_address, bus.mem_wdata);
            end else begin
              e = wr_q.pop_front();
              chk("mem_wr_addr", bus.mem_address, e.addr);
              chk("mem_wr_data", bus.mem_wdata, e.data);
            end
          end
          busy = 0;
        end else begin
          cnt++;
          bus.mem_ready = 1'b0;
          bus.mem_rdata = $urandom;
        end
      end
    end
  end

  // Response monitor.
  initial begin
    resp_t e;
    forever begin
      @(negedge clk);
      if (!reset && bus.resp_valid) begin
        if (exp_q.size() == 0) begin
          n_chk++; n_err++;
          $display("FAIL resp_unexpected: got rdata %h fault %0d", bus.resp_rdata, bus.resp_fault);
        end else begin
          e = exp_q.pop_front();
          chk("resp_rdata", bus.resp_rdata, e.rdata);
          chk("resp_fault", 32'(bus.resp_fault), 32'(e.fault));
        end
      end
    end
  end

  task automatic wait_idle();
    int g = 0;
    while (!bus.req_ready && g < 50) begin @(negedge clk); g++; end
    if (!bus.req_ready) flag("req_ready_timeout");
  endtask

  // Issue one request from a negedge; returns accept-to-response latency.
  task automatic issue(input bit w, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, output int lat, output bit saw_mem,
                       output logic [31:0] first_addr);
    lat = 0; saw_mem = 0; first_addr = '0;
    wait_idle();
    exp_q.push_back(model(w, f3, a, wd));
    bus.req_valid = 1'b1; bus.req_write = w; bus.req_funct3 = f3;
    bus.req_addr = a; bus.req_wdata = wd;
    @(posedge clk);
    do begin
      @(negedge clk);
      lat++;
      if (lat == 1) bus.req_valid = 1'b0;
      if (bus.mem_valid && !saw_mem) begin saw_mem = 1; first_addr = bus.mem_address; end
    end while (!bus.resp_valid && lat < 60);
    if (!bus.resp_valid) flag("resp_timeout");
  endtask

  task automatic dir(input string name, input bit w, input logic [2:0] f3,
                     input logic [31:0] a, input logic [31:0] wd,
                     input int exp_lat, input bit exp_mem);
    int lat; bit sm; logic [31:0] fa;
    issue(w, f3, a, wd, lat, sm, fa);
    chk({name, "_lat"}, 32'(lat), 32'(exp_lat));
    chk({name, "_memvalid"}, 32'(sm), 32'(exp_mem));
    if (exp_mem) chk({name, "_addr"}, fa, {a[31:2], 2'b00});
  endtask

  logic [2:0] ld_f3 [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};

  initial begin
    int lat, acc1, acc2, rsp1, nmv;
    bit sm;
    logic [31:0] fa, a;
    logic [2:0] f3;
    bit w;

    for (int i = 0; i < 512; i++) set_word(32'(i) << 2, $urandom);
    reset = 1'b1;
    bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_funct3 = '0;
    bus.req_addr = '0; bus.req_wdata = '0;
    repeat (2) @(negedge clk);
    chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
    chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    chk("rst_mem_valid", 32'(bus.mem_valid), 32'd0);
    chk("rst_mem_addr", bus.mem_address, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_mem_valid", 32'(bus.mem_valid), 32'd0);

    // Directed, mem_ready tied high.
    set_word(32'h404, 32'hDEADBEEF);
    dir("lw", 0, F3_W, 32'h404, 0, 2, 1);
    set_word(32'h404, 32'h123480FF);
    dir("lb", 0, F3_B, 32'h405, 0, 2, 1);
    dir("lbu", 0, F3_BU, 32'h405, 0, 2, 1);
    dir("lh", 0, F3_H, 32'h406, 0, 2, 1);
    dir("sw", 1, F3_W, 32'h408, 32'hCAFEF00D, 2, 1);
    dir("sh", 1, F3_H, 32'h40A, 32'h5A5A, 3, 1);

    // SB with delayed read.
    set_word(32'h400, 32'h11223344);
    tie_ready = 0; rd_dly = 3; wr_dly = 0;
    dir("sb_slow", 1, F3_B, 32'h402, 32'hAB, 6, 1);
    chk("sb_merge", mem_w[32'h400 >> 2], 32'h11AB3344);
    tie_ready = 1; rd_dly = 0;

    // Faults: no memory traffic, response next cycle.
    dir("f_mis", 0, F3_H, 32'h401, 0, 1, 0);
    dir("f_f3", 0, 3'b011, 32'h400, 0, 1, 0);
    dir("f_rom", 1, F3_W, 32'h100, 0, 1, 0);
    dir("f_map", 0, F3_W, 32'h800, 0, 1, 0);

    // Back-to-back loads with req_valid held.
    wait_idle();
    exp_q.push_back(model(0, F3_W, 32'h408, 0));
    exp_q.push_back(model(0, F3_W, 32'h40C, 0));
    bus.req_valid = 1; bus.req_write = 0; bus.req_funct3 = F3_W; bus.req_addr = 32'h408;
    acc1 = -1; acc2 = -1; rsp1 = -1; nmv = 0;
    for (int c = 0; c < 12; c++) begin
      if (bus.mem_valid) nmv++;
      if (bus.resp_valid && rsp1 < 0) rsp1 = c;
      if (bus.req_valid && bus.req_ready) begin
        if (acc1 < 0) acc1 = c; else if (acc2 < 0) acc2 = c;
      end else if (acc2 >= 0) bus.req_valid = 0;
      else if (acc1 >= 0) bus.req_addr = 32'h40C;
      @(negedge clk);
    end
    bus.req_valid = 0;
    chk("b2b_accept", 32'(acc2), 32'(rsp1 + 1));
    chk("b2b_memvalid_cycles", 32'(nmv), 32'd2);

    // Reset in the middle of a stalled write.
    wait_idle();
    tie_ready = 0; wr_dly = 100;
    bus.req_valid = 1; bus.req_write = 1; bus.req_funct3 = F3_W;
    bus.req_addr = 32'h410; bus.req_wdata = 32'h0BADBEEF;
    @(negedge clk);
    bus.req_valid = 0;
    @(negedge clk);
    chk("rstwr_pre_mem_valid", 32'(bus.mem_valid), 32'd1);
    reset = 1;
    @(negedge clk);
    reset = 0;
    chk("rstwr_mem_valid", 32'(bus.mem_valid), 32'd0);
    chk("rstwr_req_ready", 32'(bus.req_ready), 32'd1);
    chk("rstwr_resp_valid", 32'(bus.resp_valid), 32'd0);
    chk("rstwr_resp_rdata", bus.resp_rdata, 32'd0);
    chk("rstwr_resp_fault", 32'(bus.resp_fault), 32'd0);
    chk("rstwr_mem_rw", 32'(bus.mem_read_write), 32'd0);
    chk("rstwr_mem_addr", bus.mem_address, 32'd0);
    chk("rstwr_mem_wdata", bus.mem_wdata, 32'd0);
    @(negedge clk);
    chk("rstwr_after_mem_valid", 32'(bus.mem_valid), 32'd0);
    wr_dly = 0;

    // Randomised traffic with random memory stalls.
    rand_dly = 1;
    for (int n = 0; n < 300; n++) begin
      w = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 9) == 0) f3 = 3'($urandom_range(0, 7));
      else if (w) f3 = 3'($urandom_range(0, 2));
      else f3 = ld_f3[$urandom_range(0, 4)];
      case ($urandom_range(0, 19))
        0:       a = $urandom;
        1, 2, 3: a = 32'($urandom_range(0, 32'h3FF));
        default: a = 32'h400 + 32'($urandom_range(0, 32'h7F));
      endcase
      if ($urandom_range(0, 7) != 0) a = a & ~((32'd1 << f3[1:0]) - 32'd1);
      issue(w, f3, a, $urandom, lat, sm, fa);
    end

    repeat (5) @(negedge clk);
    chk("exp_q_drained", 32'(exp_q.size()), 32'd0);
    chk("wr_q_drained", 32'(wr_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
